data_interpolation: RTL

//  Upsampler for the DAC transmit path; the counterpart of the ADC-side decimator.
//  - Accepts one valid/ready sample stream and emits each sample (interp_reg+1) times on an output valid/ready stream.
//  - Narrows samples to the DAC word width.
//  - Sits between a DMA/stream source and the DAC pin driver; runs in one clock domain.

---
 rtl/data_interpolation.sv | 106 ++++++++++
 1 files changed

// File: rtl/data_interpolation.sv
// rtl/data_interpolation.sv - stream upsampler: repeats each input sample (interp_reg+1) times, narrowed to DAC width
// Optional build macro: INTERP_ZERO_STUFF_EN (zero-stuffed repeats instead of zero-order hold).
module data_interpolation #(
  parameter int DATA_IN_WIDTH  = 16,
  parameter int DATA_OUT_WIDTH = 12,
  parameter int DATA_REG_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_REG_WIDTH-1:0] interp_reg,
  input  logic [DATA_IN_WIDTH-1:0]  in_data,
  input  logic                      in_data_valid,
  output logic                      in_data_ready,
  output logic [DATA_OUT_WIDTH-1:0] out_data,
  output logic                      out_data_valid,
  input  logic                      out_data_ready,
  output logic [DATA_REG_WIDTH-1:0] underrun_cnt
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [DATA_REG_WIDTH-1:0] ONE = {{(DATA_REG_WIDTH-1){1'b0}}, 1'b1};

  state_t                    state;
  state_t                    state_nxt;
  logic [DATA_OUT_WIDTH-1:0] sample_q;
  logic [DATA_REG_WIDTH-1:0] cnt;
  logic [DATA_REG_WIDTH-1:0] factor_q;
  logic                      started;

  logic                      in_xfer;
  logic                      out_xfer;
  logic                      last_beat;
  logic [DATA_OUT_WIDTH-1:0] narrow;
  logic [DATA_OUT_WIDTH-1:0] repeat_data;
  logic                      unused_bits;

  assign out_xfer  = out_data_valid & out_data_ready;
  assign last_beat = (cnt == factor_q);
  assign in_xfer   = in_data_valid & in_data_ready;
  assign narrow    = in_data[DATA_IN_WIDTH-1 -: DATA_OUT_WIDTH];

`ifdef INTERP_ZERO_STUFF_EN
  assign repeat_data = '0;
`else
  assign repeat_data = sample_q;
`endif

  // LSBs below the DAC width are deliberately dropped.
  assign unused_bits = ^{in_data, sample_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_xfer) state_nxt = EMIT;
      EMIT: if (out_xfer && last_beat && !in_xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accepting on the final beat lets bursts run back to back with no bubble.
  always_comb begin
    in_data_ready = (state == IDLE) | (out_xfer & last_beat);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q       <= '0;
      out_data       <= '0;
      out_data_valid <= 1'b0;
      cnt            <= '0;
      factor_q       <= '0;
      started        <= 1'b0;
      underrun_cnt   <= '0;
    end else begin
      if (in_xfer) begin
        sample_q       <= narrow;
        out_data       <= narrow;
        out_data_valid <= 1'b1;
        factor_q       <= interp_reg;
        cnt            <= '0;
        started        <= 1'b1;
      end else if (out_xfer) begin
        if (!last_beat) begin
          cnt      <= cnt + ONE;
          out_data <= repeat_data;
        end else begin
          out_data_valid <= 1'b0;
        end
      end

      if (started && out_data_ready && !out_data_valid && (underrun_cnt != '1)) begin
        underrun_cnt <= underrun_cnt + ONE;
      end
    end
  end

endmodule
